// File: rtl/neg_arbiter_pkg.sv
// Shared definitions for the neg_arbiter block.
//   state_e    : FSM state type (IDLE, NEG, RESP), 2-bit encoding
//   DATA_WIDTH : default operand/result width (32)
//   MIN_NEG    : most negative 32-bit two's-complement value
package neg_arbiter_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] MIN_NEG    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEG  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/negate.sv
// Two's-complement negate datapath: out = ~A + 1 (mod 2^WIDTH).
// Ports:
//   A   : operand
//   out : negated operand
module negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] out
);

  assign out = ~A + WIDTH'(1);

endmodule

// File: rtl/neg_arbiter.sv
// Two-requester round-robin arbiter in front of a single negate unit.
// Each accepted operand is registered, negated in the NEG state and held in
// RESP until the consumer takes it.
// Optional feature macro: NEG_ARBITER_OVF_EN (registered most-negative flag
// on rsp_ovf; when undefined rsp_ovf is constant 0).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req0_valid/req0_data/req0_ready  : requester 0 operand handshake
//   req1_valid/req1_data/req1_ready  : requester 1 operand handshake
//   rsp_valid/rsp_id/rsp_data/rsp_ovf/rsp_ready : tagged result handshake
//   busy                             : high whenever not in IDLE
module neg_arbiter
  import neg_arbiter_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             id_q, id_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] neg_out;
  logic             grant_id;
  logic             in_idle;
  logic             accept;

  negate #(.WIDTH(WIDTH)) u_negate (
    .A   (op_q),
    .out (neg_out)
  );

  // With both requesters valid the priority bit decides; otherwise the single
  // valid requester (if any) is chosen.
  assign grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
  // Gating with rst keeps every combinational output at 0 during reset.
  assign in_idle  = (state_q == IDLE) && !rst;
  assign accept   = in_idle && (req0_valid || req1_valid);

  assign req0_ready = in_idle && req0_valid && !grant_id;
  assign req1_ready = in_idle && req1_valid &&  grant_id;
  assign rsp_valid  = !rst && (state_q == RESP);
  assign busy       = !rst && (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

  // NOTE: every variable assigned here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    id_d       = id_q;
    prio_d     = prio_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = grant_id ? req1_data : req0_data;
          id_d    = grant_id;
          prio_d  = ~grant_id;
          state_d = NEG;
        end
      end
      NEG: begin
        rsp_data_d = neg_out;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      id_q       <= 1'b0;
      prio_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef NEG_ARBITER_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;

  always_comb begin
    rsp_ovf_d = rsp_ovf_q;
    if (state_q == NEG) rsp_ovf_d = (op_q == {1'b1, {(WIDTH-1){1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_ovf_q <= 1'b0;
    else     rsp_ovf_q <= rsp_ovf_d;
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_neg_arbiter.sv
module tb_neg_arbiter;
  import neg_arbiter_pkg::*;

  localparam int W = DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf, busy;
  logic [W-1:0] rsp_data;

  always #5 clk = ~clk;

  neg_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one outstanding operation at most, a
  // priority bit, and the result the consumer should currently see.
  bit           m_pending;
  int           m_age;      // cycles since capture (1 = negating, >=2 = responding)
  bit           m_prio;
  bit           m_id;
  logic [W-1:0] m_data;
  bit           m_ovf;
  logic [W-1:0] l_data;
  bit           l_id, l_ovf;

  // Observed DUT events.
  int cyc;
  int acc_cycle[$];
  bit acc_id[$];
  int rsp_cycle[$];
  bit rsp_id_log[$];
  logic [W-1:0] rsp_data_log[$];

  function automatic bit exp_ovf(input logic [W-1:0] d);
`ifdef NEG_ARBITER_OVF_EN
    return d == MIN_NEG;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive, check at negedge, advance model for the edge.
  task automatic cycle(input bit r, input bit v0, input logic [W-1:0] d0,
                       input bit v1, input logic [W-1:0] d1, input bit rr,
                       output bit a0, output bit a1);
    bit e_valid, e_busy, e_r0, e_r1;
    logic [W-1:0] src;
    rst = r; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; rsp_ready = rr;
    @(negedge clk);
    e_valid = !r && m_pending && m_age >= 2;
    e_busy  = !r && m_pending;
    e_r0    = !r && !m_pending && v0 && (!v1 || m_prio == 1'b0);
    e_r1    = !r && !m_pending && v1 && (!v0 || m_prio == 1'b1);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("busy", busy, e_busy);
    check("rsp_valid", rsp_valid, e_valid);
    if (!r) begin
      check("rsp_data", rsp_data, l_data);
      check("rsp_id", rsp_id, l_id);
      check("rsp_ovf", rsp_ovf, l_ovf);
    end
    a0 = v0 && req0_ready;
    a1 = v1 && req1_ready;
    if (a0 || a1) begin acc_cycle.push_back(cyc); acc_id.push_back(a1); end
    if (rsp_valid && rr) begin
      rsp_cycle.push_back(cyc); rsp_id_log.push_back(rsp_id); rsp_data_log.push_back(rsp_data);
    end
    if (r) begin
      m_pending = 0; m_prio = 0; l_data = '0; l_id = 0; l_ovf = 0;
    end else if (m_pending) begin
      if (m_age == 1) begin
        l_data = m_data; l_id = m_id; l_ovf = m_ovf; m_age = 2;
      end else if (rr) begin
        m_pending = 0;
      end else begin
        m_age++;
      end
    end else if (e_r0 || e_r1) begin
      src       = e_r1 ? d1 : d0;
      m_id      = e_r1;
      m_data    = '0 - src;
      m_ovf     = exp_ovf(src);
      m_prio    = !m_id;
      m_pending = 1;
      m_age     = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MIN_NEG;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a0, a1, v0, v1;
    logic [W-1:0] d0, d1;
    int b, rb, t;

    cyc = 0;
    rst = 1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; rsp_ready = 0;
    @(posedge clk); #1;

    // Reset values, including combinational outputs with a requester valid.
    cycle(1, 1, 32'd9, 0, '0, 1, a0, a1);
    cycle(1, 0, '0, 0, '0, 0, a0, a1);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);

    // Single request, data 5.
    cycle(0, 1, 32'd5, 0, '0, 1, a0, a1);
    check("t1_accept", a0, 1'b1);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);
    check("t1_lat_valid", rsp_valid, 1'b1);
    check("t1_data", rsp_data, 32'hFFFF_FFFB);
    check("t1_id", rsp_id, 1'b0);
    check("t1_ovf", rsp_ovf, 1'b0);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);

    // Both valid from reset.
    cycle(1, 0, '0, 0, '0, 0, a0, a1);
    b = acc_id.size(); rb = rsp_id_log.size();
    v0 = 1; v1 = 1;
    for (int i = 0; i < 9; i++) begin
      cycle(0, v0, 32'hFFFF_FFFF, v1, 32'h0, 1, a0, a1);
      if (a0) v0 = 0;
      if (a1) v1 = 0;
    end
    check("t2_n_rsp", rsp_id_log.size() - rb, 2);
    if (rsp_id_log.size() - rb >= 2 && acc_id.size() - b >= 2) begin
      check("t2_id0", rsp_id_log[rb], 1'b0);
      check("t2_data0", rsp_data_log[rb], 32'h0000_0001);
      check("t2_id1", rsp_id_log[rb+1], 1'b1);
      check("t2_data1", rsp_data_log[rb+1], 32'h0);
      check("t2_gap", acc_cycle[b+1] - acc_cycle[b], 3);
    end

    // Continuous contention: six grants alternate starting at 0.
    cycle(1, 0, '0, 0, '0, 0, a0, a1);
    b = acc_id.size();
    for (int i = 0; i < 18; i++) cycle(0, 1, pick(), 1, pick(), 1, a0, a1);
    check("t3_grants", acc_id.size() - b, 6);
    for (int k = 0; k < 6 && b + k < acc_id.size(); k++)
      check($sformatf("t3_id%0d", k), acc_id[b+k], k[0]);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);

    // Most-negative operand from requester 1 under back-pressure.
    cycle(1, 0, '0, 0, '0, 0, a0, a1);
    cycle(0, 0, '0, 1, MIN_NEG, 0, a0, a1);
    check("t4_accept", a1, 1'b1);
    cycle(0, 0, '0, 0, '0, 0, a0, a1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 32'h55, 1, 32'h66, 0, a0, a1);
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_data", rsp_data, MIN_NEG);
      check("t4_hold_id", rsp_id, 1'b1);
      check("t4_ovf", rsp_ovf, exp_ovf(MIN_NEG));
      check("t4_busy", busy, 1'b1);
      check("t4_rdy", {req0_ready, req1_ready}, 2'b00);
    end
    cycle(0, 0, '0, 0, '0, 1, a0, a1);
    check("t4_release_busy", busy, 1'b0);
    check("t4_release_valid", rsp_valid, 1'b0);

    // Reset while negating: no response, priority back to 0.
    cycle(0, 1, 32'h1234, 0, '0, 1, a0, a1);
    rb = rsp_id_log.size();
    cycle(1, 0, '0, 0, '0, 1, a0, a1);
    check("t5_valid", rsp_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_data", rsp_data, '0);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, '0, 1, a0, a1);
    check("t5_no_rsp", rsp_id_log.size() - rb, 0);
    b = acc_id.size();
    cycle(0, 1, 32'h10, 1, 32'h20, 1, a0, a1);
    check("t5_grant_n", acc_id.size() - b, 1);
    if (acc_id.size() > b) check("t5_grant_id", acc_id[b], 1'b0);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);
    cycle(0, 0, '0, 0, '0, 1, a0, a1);

    // Randomized traffic with protocol-legal requesters.
    v0 = 0; v1 = 0; d0 = '0; d1 = '0;
    for (int i = 0; i < 500; i++) begin
      t = ($urandom_range(0, 63) == 0) ? 1 : 0;
      cycle(t[0], v0, d0, v1, d1, $urandom_range(0, 2) != 0, a0, a1);
      if (v0 && !a0 && !t[0]) begin
        if ($urandom_range(0, 15) == 0) v0 = 0;
      end else begin
        v0 = $urandom_range(0, 2) != 0; d0 = pick();
      end
      if (v1 && !a1 && !t[0]) begin
        if ($urandom_range(0, 15) == 0) v1 = 0;
      end else begin
        v1 = $urandom_range(0, 2) != 0; d1 = pick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
